// File: rtl/uart_ascii_pkg.sv
// Shared ASCII constants, hex-decoder result type and FSM state encoding
// for the UART command blocks.
package uart_ascii_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_F = 8'h46;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_F = 8'h66;

    // Command FSM encoding; the ECHO states exist only in echo builds.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_POP     = 3'd1;
    localparam logic [2:0] ST_PARSE   = 3'd2;
    localparam logic [2:0] ST_ECHO    = 3'd3;
    localparam logic [2:0] ST_ECHO_LF = 3'd4;

    typedef struct packed {
        logic       is_hex;
        logic [3:0] nibble;
    } hex_dec_t;

endpackage

// File: rtl/uart_hex_cmd_if.sv
// UART FIFO handshake bundle between the uart block and a command consumer.
// master = consumer (pops rx, pushes tx); slave = the uart FIFO side.
interface uart_hex_cmd_if;

    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;

    modport master (
        input  rx_empty, r_data, tx_full,
        output rd_uart, w_data, wr_uart
    );

    modport slave (
        output rx_empty, r_data, tx_full,
        input  rd_uart, w_data, wr_uart
    );

endinterface

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII byte -> {is_hex, nibble}. Accepts 0-9, A-F, a-f;
// anything else reports is_hex=0 with nibble 0.
module hex_ascii_decode
    import uart_ascii_pkg::*;
(
    input  logic [7:0] ch_in,
    output hex_dec_t   dec
);

    // Range-check the byte and map the letter ranges onto 10..15.
    always_comb begin
        dec = '0;
        if (ch_in >= ASCII_0 && ch_in <= ASCII_9) begin
            dec.is_hex = 1'b1;
            dec.nibble = ch_in[3:0];
        end else if ((ch_in >= ASCII_UC_A && ch_in <= ASCII_UC_F) ||
                     (ch_in >= ASCII_LC_A && ch_in <= ASCII_LC_F)) begin
            dec.is_hex = 1'b1;
            dec.nibble = ch_in[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_cmd.sv
// uart_hex_cmd: pops bytes from the UART rx FIFO, parses ASCII hex lines
// terminated by CR into a DIGITS-wide value for the display path.
// Build option: define UART_HEX_CMD_ECHO_EN to echo every received byte
// (plus LF after CR) into the tx FIFO; otherwise wr_uart/w_data are tied 0.
module uart_hex_cmd
    import uart_ascii_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    uart_hex_cmd_if.master        uart,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic                  err
);

    localparam int VW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);

    logic [2:0]    state_q, state_d;
    logic [7:0]    ch_q, ch_d;
    logic [VW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          discard_q, discard_d;
    logic [VW-1:0] value_q, value_d;
    logic          value_valid_q, value_valid_d;
    logic          err_q, err_d;
    logic          rd_uart_q, rd_uart_d;
`ifdef UART_HEX_CMD_ECHO_EN
    logic          wr_uart_q, wr_uart_d;
    logic [7:0]    w_data_q, w_data_d;
`endif

    hex_dec_t dec;

    hex_ascii_decode u_decode (
        .ch_in (ch_q),
        .dec   (dec)
    );

    // Next-state logic: one byte in flight, pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        discard_d     = discard_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        err_d         = 1'b0;
        rd_uart_d     = 1'b0;
`ifdef UART_HEX_CMD_ECHO_EN
        wr_uart_d     = 1'b0;
        w_data_d      = w_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!uart.rx_empty) begin
                    rd_uart_d = 1'b1;
                    state_d   = ST_POP;
                end
            end
            ST_POP: begin
                ch_d    = uart.r_data;
                state_d = ST_PARSE;
            end
            ST_PARSE: begin
                if (ch_q == ASCII_CR) begin
                    if (!discard_q && cnt_q != '0) begin
                        value_d       = acc_q;
                        value_valid_d = 1'b1;
                    end
                    acc_d     = '0;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                end else if (ch_q == ASCII_LF) begin
                    acc_d = acc_q;
                end else if (dec.is_hex) begin
                    if (!discard_q) begin
                        if (cnt_q < DIGITS_C) begin
                            acc_d = (acc_q << 4) | VW'(dec.nibble);
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            err_d     = 1'b1;
                            discard_d = 1'b1;
                        end
                    end
                end else if (!discard_q) begin
                    err_d     = 1'b1;
                    discard_d = 1'b1;
                end
`ifdef UART_HEX_CMD_ECHO_EN
                state_d = ST_ECHO;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef UART_HEX_CMD_ECHO_EN
            ST_ECHO: begin
                if (!uart.tx_full && !wr_uart_q) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = ch_q;
                    state_d   = (ch_q == ASCII_CR) ? ST_ECHO_LF : ST_IDLE;
                end
            end
            ST_ECHO_LF: begin
                if (!uart.tx_full && !wr_uart_q) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = ASCII_LF;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any partial line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            discard_q     <= 1'b0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            err_q         <= 1'b0;
            rd_uart_q     <= 1'b0;
`ifdef UART_HEX_CMD_ECHO_EN
            wr_uart_q     <= 1'b0;
            w_data_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            discard_q     <= discard_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            err_q         <= err_d;
            rd_uart_q     <= rd_uart_d;
`ifdef UART_HEX_CMD_ECHO_EN
            wr_uart_q     <= wr_uart_d;
            w_data_q      <= w_data_d;
`endif
        end
    end

    assign value        = value_q;
    assign value_valid  = value_valid_q;
    assign err          = err_q;
    assign uart.rd_uart = rd_uart_q;
`ifdef UART_HEX_CMD_ECHO_EN
    assign uart.wr_uart = wr_uart_q;
    assign uart.w_data  = w_data_q;
`else
    logic unused_tx_full;
    assign unused_tx_full = uart.tx_full;
    assign uart.wr_uart   = 1'b0;
    assign uart.w_data    = 8'h00;
`endif

endmodule

// File: tb/tb_uart_hex_cmd.sv
// Self-checking bench for uart_hex_cmd: rx FIFO model, reference line parser
// feeding an event scoreboard, and echo scoreboard in UART_HEX_CMD_ECHO_EN builds.
module tb_uart_hex_cmd;
    import uart_ascii_pkg::*;

    localparam int DIGITS = 2;
    localparam int VW     = 4 * DIGITS;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [VW-1:0] value;
    logic          value_valid;
    logic          err;

    uart_hex_cmd_if bus ();

    uart_hex_cmd #(.DIGITS(DIGITS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .uart        (bus),
        .value       (value),
        .value_valid (value_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    logic [7:0] echo_q[$];
    logic [7:0] rx_fifo[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         vv_count = 0, err_count = 0, rd_count = 0, wr_count = 0;
    int         m_cnt = 0;
    bit         m_disc = 0;
    logic [7:0] m_acc = '0;
    logic       fifo_pop;
    exp_t       mon_e;

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference parser: predicts commits/errors (and echo bytes) for one byte.
    task automatic modelByte(input logic [7:0] b);
        bit         hex;
        logic [3:0] nib;
        hex = 1'b1;
        nib = 4'h0;
        if (b >= "0" && b <= "9") nib = 4'(b - 8'h30);
        else if (b >= "A" && b <= "F") nib = 4'(b - 8'h37);
        else if (b >= "a" && b <= "f") nib = 4'(b - 8'h57);
        else hex = 1'b0;
        echo_q.push_back(b);
        if (b == 8'h0D) begin
            echo_q.push_back(8'h0A);
            if (!m_disc && m_cnt > 0) exp_q.push_back('{1'b0, m_acc});
            m_disc = 0;
            m_cnt  = 0;
            m_acc  = '0;
        end else if (b == 8'h0A) begin
            m_cnt = m_cnt;
        end else if (hex) begin
            if (!m_disc) begin
                if (m_cnt < DIGITS) begin
                    m_acc = {m_acc[3:0], nib};
                    m_cnt++;
                end else begin
                    exp_q.push_back('{1'b1, 8'h00});
                    m_disc = 1;
                end
            end
        end else if (!m_disc) begin
            exp_q.push_back('{1'b1, 8'h00});
            m_disc = 1;
        end
    endtask

    // Queue a string into the rx FIFO and predict its effect.
    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_fifo.push_back(s[i]);
            modelByte(s[i]);
        end
    endtask

    // Wait (bounded) for the FIFO to drain and the last byte to settle.
    task automatic waitDrain();
        int n;
        n = 0;
        while (rx_fifo.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 32'(rx_fifo.size() == 0), 1);
        repeat (12) @(negedge clk);
        checkOutput("pending_events", exp_q.size(), 0);
`ifdef UART_HEX_CMD_ECHO_EN
        checkOutput("pending_echo", echo_q.size(), 0);
`endif
    endtask

    // rx FIFO model: pops on rd_uart seen at the edge, updates head just after.
    always @(posedge clk) begin
        fifo_pop = bus.rd_uart;
        #1;
        if (fifo_pop && rx_fifo.size() != 0) void'(rx_fifo.pop_front());
        bus.rx_empty = (rx_fifo.size() == 0);
        bus.r_data   = (rx_fifo.size() != 0) ? rx_fifo[0] : 8'h00;
    end

    // Output monitor on the falling edge: scoreboard pops and pulse counters.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.rd_uart) begin
                rd_count++;
                checkOutput("rd_while_empty", bus.rx_empty, 0);
            end
            if (value_valid) begin
                vv_count++;
                if (exp_q.size() == 0) checkOutput("extra_commit", value_valid, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("commit_expected", value_valid, !mon_e.is_err);
                    if (!mon_e.is_err) checkOutput("commit_value", value, mon_e.data);
                end
            end
            if (err) begin
                err_count++;
                if (exp_q.size() == 0) checkOutput("extra_err", err, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("err_expected", err, mon_e.is_err);
                end
            end
`ifdef UART_HEX_CMD_ECHO_EN
            if (bus.wr_uart) begin
                wr_count++;
                if (echo_q.size() == 0) checkOutput("extra_echo", bus.wr_uart, 0);
                else checkOutput("echo_byte", bus.w_data, echo_q.pop_front());
            end
`else
            if (bus.wr_uart) begin
                wr_count++;
                checkOutput("wr_uart_tied", bus.wr_uart, 0);
            end
`endif
        end
    end

    // Directed line tests, random lines, then async reset mid-line.
    initial begin
        int v0, e0, r0, w0, rd_at, err_at;
        string pool;
        string line;
        reset_n     = 1'b0;
        bus.tx_full = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_value", value, 0);
        checkOutput("reset_valid", value_valid, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_rd", bus.rd_uart, 0);
        checkOutput("reset_wr", bus.wr_uart, 0);
        checkOutput("reset_wdata", bus.w_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        rd_at  = 0;
        err_at = 0;
        applyStimulus("Z");
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.rd_uart && rd_at == 0) rd_at = i;
            if (err && err_at == 0) err_at = i;
        end
        checkOutput("latency_rd", rd_at, 2);
        checkOutput("latency_err", err_at, 4);
        applyStimulus("\r");
        waitDrain();

        v0 = vv_count; e0 = err_count; r0 = rd_count;
        applyStimulus("3F\r");
        waitDrain();
        checkOutput("3F_value", value, 8'h3F);
        checkOutput("3F_commits", vv_count - v0, 1);
        checkOutput("3F_errs", err_count - e0, 0);
        checkOutput("3F_pops", rd_count - r0, 3);

        applyStimulus("a\r");
        waitDrain();
        checkOutput("a_value", value, 8'h0A);
        v0 = vv_count;
        applyStimulus("\r");
        waitDrain();
        checkOutput("empty_commits", vv_count - v0, 0);
        checkOutput("empty_hold", value, 8'h0A);

        v0 = vv_count; e0 = err_count;
        applyStimulus("123\r");
        waitDrain();
        checkOutput("ovf_errs", err_count - e0, 1);
        checkOutput("ovf_commits", vv_count - v0, 0);
        applyStimulus("55\r");
        waitDrain();
        checkOutput("55_value", value, 8'h55);

        v0 = vv_count; e0 = err_count;
        applyStimulus("4G7\r");
        waitDrain();
        checkOutput("bad_errs", err_count - e0, 1);
        checkOutput("bad_commits", vv_count - v0, 0);
        checkOutput("bad_hold", value, 8'h55);
        e0 = err_count;
        applyStimulus("\n");
        waitDrain();
        checkOutput("lf_errs", err_count - e0, 0);

        applyStimulus("bE\r9\n0\r");
        waitDrain();
        checkOutput("lf_midline_value", value, 8'h90);

`ifdef UART_HEX_CMD_ECHO_EN
        bus.tx_full = 1'b1;
        r0 = rd_count; w0 = wr_count;
        applyStimulus("12\r");
        repeat (20) @(negedge clk);
        checkOutput("full_pops", rd_count - r0, 1);
        checkOutput("full_pushes", wr_count - w0, 0);
        bus.tx_full = 1'b0;
        waitDrain();
        checkOutput("echo_pushes", wr_count - w0, 4);
        checkOutput("12_value", value, 8'h12);
`endif

        pool = "09aF7cE\nxZ3";
        for (int l = 0; l < 8; l++) begin
            line = "";
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                line = {line, string'(pool[$urandom_range(0, pool.len() - 1)])};
            applyStimulus({line, "\r"});
        end
        waitDrain();

        applyStimulus("12\r");
        waitDrain();
        applyStimulus("1");
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_value", value, 0);
        checkOutput("async_valid", value_valid, 0);
        checkOutput("async_err", err, 0);
        checkOutput("async_rd", bus.rd_uart, 0);
        m_cnt = 0; m_disc = 0; m_acc = '0;
        exp_q.delete();
        echo_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus("2\r");
        waitDrain();
        checkOutput("post_reset_value", value, 8'h02);
        checkOutput("wr_tied_count",
`ifdef UART_HEX_CMD_ECHO_EN
                    32'(wr_count > 0), 1);
`else
                    wr_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
